debug_controller: RTL and testbench



---
 rtl/mips_dbg_pkg.sv | 36 +++
 rtl/dbg_tx_sequencer.sv | 95 +++++++++
 rtl/debug_controller.sv | 157 +++++++++++++++
 tb/tb_debug_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS pipeline run-control debug block.
// Holds the UART command bytes, the report framing constants, the shared
// FSM state encoding and a helper that packs the 9-byte report payload.
package mips_dbg_pkg;

  localparam logic [7:0] CMD_CONT   = 8'h63;
  localparam logic [7:0] CMD_STEP   = 8'h73;
  localparam logic [7:0] CMD_BREAK  = 8'h62;
  localparam logic [7:0] CMD_RESET  = 8'h72;

  localparam logic [3:0] STATUS_SIG = 4'hA;
  localparam logic [7:0] NAK_BYTE   = 8'h3F;

  localparam int REPORT_LEN = 9;
  localparam int PAYLOAD_W  = 8 * REPORT_LEN;

  typedef enum logic [3:0] {
    IDLE,
    RUN,
    STEP,
    PRESET,
    REPORT_LOAD,
    REPORT_SEND,
    REPORT_WAIT_BUSY,
    REPORT_WAIT_DONE,
    NAK
  } dbg_state_e;

  // Report layout, first byte transmitted in the top bits.
  function automatic logic [PAYLOAD_W-1:0] pack_report(input logic [7:0]  status,
                                                       input logic [31:0] pc,
                                                       input logic [31:0] cnt);
    return {status, pc, cnt};
  endfunction

endpackage

// File: rtl/dbg_tx_sequencer.sv
// Serialises up to REPORT_LEN bytes onto the UART transmitter handshake.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   start          - one-cycle request; payload/len are captured on it
//   len            - number of bytes to send (1..REPORT_LEN)
//   payload        - bytes to send, first byte in the MSBs
//   tx_busy        - transmitter busy, high from the cycle after tx_start
//   tx_data        - byte presented to the transmitter (held between bytes)
//   tx_start       - one-cycle launch pulse
//   done           - one-cycle pulse when the last byte has completed
module dbg_tx_sequencer
  import mips_dbg_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           len,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic                 done
);

  dbg_state_e           state_q, state_d;
  logic [PAYLOAD_W-1:0] shift_q, shift_d;
  logic [3:0]           remain_q, remain_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      remain_q   <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Payload shift register is pure data; a stale value is never transmitted
  // because a new start always reloads it.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    remain_d   = remain_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = payload;
          remain_d = len;
          state_d  = REPORT_SEND;
        end
      end
      REPORT_SEND: begin
        if (!tx_busy) begin
          tx_data_d  = shift_q[PAYLOAD_W-1 -: 8];
          tx_start_d = 1'b1;
          shift_d    = {shift_q[PAYLOAD_W-9:0], 8'h00};
          state_d    = REPORT_WAIT_BUSY;
        end
      end
      REPORT_WAIT_BUSY: begin
        if (tx_busy) state_d = REPORT_WAIT_DONE;
      end
      REPORT_WAIT_DONE: begin
        if (!tx_busy) begin
          if (remain_q == 4'd1) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            remain_d = remain_q - 4'd1;
            state_d  = REPORT_SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: rtl/debug_controller.sv
// Run-control sequencer for the 5-stage MIPS pipeline. Decodes UART command
// bytes (continue, step, break, pipeline reset), gates the pipeline with a
// global enable and returns a 9-byte status/PC/cycle-count report after each
// operation (or a single '?' byte for an unknown command).
// Ports:
//   clk, reset           - clock, synchronous active-high controller reset
//   rx_data, rx_valid    - received command byte and its one-cycle strobe
//   tx_data, tx_start    - byte to transmit and its one-cycle launch pulse
//   tx_busy              - transmitter busy
//   halt_wb              - HALT instruction in WB (valid while pipe_en=1)
//   pc_value             - current IF-stage PC
//   pipe_en              - enable for PC and all pipeline latches
//   pipe_reset           - one-cycle reset pulse for datapath registers
//   running              - high while free-running
module debug_controller
  import mips_dbg_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int CNT_W    = 32,
  parameter int WATCHDOG = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  input  logic            tx_busy,
  input  logic            halt_wb,
  input  logic [PC_W-1:0] pc_value,
  output logic            pipe_en,
  output logic            pipe_reset,
  output logic            running
);

  localparam int WD_W = $clog2(WATCHDOG + 1);

  dbg_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
  logic                 halted_q, halted_d;
  logic [3:1]           flags_q, flags_d;    // preset, break, timeout
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic                 seq_start, seq_done;
  logic [3:0]           seq_len;
  logic [PAYLOAD_W-1:0] seq_payload;
  logic [31:0]          pc_ext, cnt_ext;
  logic                 wd_hit, brk_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cycle_cnt_q <= '0;
      halted_q    <= 1'b0;
      flags_q     <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      halted_q    <= halted_d;
      flags_q     <= flags_d;
      wdog_q      <= wdog_d;
    end
  end

  always_comb begin
    pipe_en    = (state_q == RUN) || (state_q == STEP);
    running    = (state_q == RUN);
    pipe_reset = (state_q == PRESET);
    pc_ext     = '0;
    pc_ext[PC_W-1:0]   = pc_value;
    cnt_ext    = '0;
    cnt_ext[CNT_W-1:0] = cycle_cnt_q;
    wd_hit     = (wdog_q == WD_W'(WATCHDOG - 1));
    brk_hit    = rx_valid && (rx_data == CMD_BREAK);
  end

  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    flags_d     = flags_q;
    wdog_d      = wdog_q;
    seq_start   = 1'b0;
    seq_len     = 4'(REPORT_LEN);
    // Halted state doubles as status bit0 so a halted core keeps reporting it.
    seq_payload = pack_report({STATUS_SIG, flags_q, halted_q}, pc_ext, cnt_ext);
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_CONT: begin
              wdog_d  = '0;
              state_d = halted_q ? REPORT_LOAD : RUN;
            end
            CMD_STEP:  state_d = halted_q ? REPORT_LOAD : STEP;
            CMD_RESET: state_d = PRESET;
            default: begin
              seq_start   = 1'b1;
              seq_len     = 4'd1;
              seq_payload = {NAK_BYTE, {(PAYLOAD_W-8){1'b0}}};
              state_d     = NAK;
            end
          endcase
        end
      end
      RUN: begin
        wdog_d = wdog_q + 1'b1;
        if (halt_wb) halted_d   = 1'b1;
        if (wd_hit)  flags_d[1] = 1'b1;
        if (brk_hit) flags_d[2] = 1'b1;
        if (halt_wb || wd_hit || brk_hit) state_d = REPORT_LOAD;
      end
      STEP: begin
        if (halt_wb) halted_d = 1'b1;
        state_d = REPORT_LOAD;
      end
      PRESET: begin
        halted_d   = 1'b0;
        flags_d[3] = 1'b1;
        state_d    = REPORT_LOAD;
      end
      // The sequencer captures the payload here, which is the report snapshot.
      REPORT_LOAD: begin
        seq_start = 1'b1;
        state_d   = REPORT_SEND;
      end
      REPORT_SEND: begin
        if (seq_done) begin
          flags_d = '0;
          state_d = IDLE;
        end
      end
      NAK: begin
        if (seq_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (state_q == PRESET)            cycle_cnt_d = '0;
    else if (pipe_en && !(&cycle_cnt_q)) cycle_cnt_d = cycle_cnt_q + 1'b1;
  end

  dbg_tx_sequencer u_tx_seq (
    .clk      (clk),
    .reset    (reset),
    .start    (seq_start),
    .len      (seq_len),
    .payload  (seq_payload),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (seq_done)
  );

endmodule

// File: tb/tb_debug_controller.sv
// Bench for debug_controller: models a UART transmitter with random busy time,
// a PC that advances by 4 per enabled cycle, and predicts every report from the
// command semantics (enabled-cycle count, status bits, PC, cycle count).
module tb_debug_controller;
  import mips_dbg_pkg::*;

  localparam int WD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        halt_wb;
  logic [31:0] pc_value = 32'h0;
  logic        pipe_en, pipe_reset, running;

  always #5 clk = ~clk;

  debug_controller #(.PC_W(32), .CNT_W(32), .WATCHDOG(WD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .halt_wb    (halt_wb),
    .pc_value   (pc_value),
    .pipe_en    (pipe_en),
    .pipe_reset (pipe_reset),
    .running    (running)
  );

  // Environment models
  logic [7:0] txlog[$];
  int en_total = 0, pre_total = 0, run_total = 0, viol_total = 0;
  int busy_left = 0;
  int halt_target = 0, en_base = 0;

  assign halt_wb = (halt_target != 0) && ((en_total - en_base) == halt_target - 1);

  always @(posedge clk) begin
    if (pipe_en === 1'b1)    en_total  <= en_total + 1;
    if (pipe_reset === 1'b1) pre_total <= pre_total + 1;
    if (running === 1'b1)    run_total <= run_total + 1;
    if (pipe_reset === 1'b1)   pc_value <= 32'h0;
    else if (pipe_en === 1'b1) pc_value <= pc_value + 32'd4;
    if (tx_start === 1'b1) begin
      if (tx_busy) viol_total <= viol_total + 1;
      txlog.push_back(tx_data);
      tx_busy   <= 1'b1;
      busy_left <= $urandom_range(1, 4);
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left <= 0;
      tx_busy   <= 1'b0;
    end
  end

  // Reference state
  logic [31:0] m_pc = 32'h0, m_cnt = 32'h0;
  logic        m_halt = 1'b0;

  int n_vec = 0, n_bad = 0;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Issues one command and checks the resulting enables, pulses and reply.
  task automatic test_cmd(input string name, input logic [7:0] cmd,
                          input int brk, input int h, input bit drop);
    logic [7:0] exp_b[9];
    logic [7:0] got;
    logic [3:0] fl;
    int exp_len, exp_en, exp_pre, exp_run;
    int tb0, eb, pb, rb, vb;
    bit done;
    fl = 4'h0; exp_pre = 0; exp_en = 0; exp_len = 9;
    if (cmd == CMD_RESET) begin
      exp_pre = 1; m_pc = 0; m_cnt = 0; m_halt = 1'b0; fl[3] = 1'b1;
    end else if (cmd == CMD_STEP) begin
      if (!m_halt) begin
        exp_en = 1;
        if (h == 1) m_halt = 1'b1;
      end
    end else if (cmd == CMD_CONT) begin
      if (!m_halt) begin
        exp_en = WD;
        if (h > 0 && h < exp_en) exp_en = h;
        if (brk >= 0 && brk + 2 < exp_en) exp_en = brk + 2;
        if (h == exp_en) m_halt = 1'b1;
        if (brk >= 0 && brk + 2 == exp_en) fl[2] = 1'b1;
        if (exp_en == WD) fl[1] = 1'b1;
      end
    end else begin
      exp_len = 1;
    end
    m_pc  = m_pc + 32'(4 * exp_en);
    m_cnt = m_cnt + 32'(exp_en);
    fl[0] = m_halt;
    exp_run = (cmd == CMD_CONT) ? exp_en : 0;
    exp_b[0] = (exp_len == 1) ? 8'h3F : {4'hA, fl};
    for (int i = 0; i < 4; i++) begin
      exp_b[1+i] = m_pc[31-8*i -: 8];
      exp_b[5+i] = m_cnt[31-8*i -: 8];
    end

    eb = en_total; pb = pre_total; rb = run_total; vb = viol_total; tb0 = txlog.size();
    en_base = en_total;
    halt_target = (cmd == CMD_CONT || cmd == CMD_STEP) ? h : 0;
    send_byte(cmd);
    if (cmd == CMD_CONT && brk >= 0) begin
      repeat (brk) @(negedge clk);
      send_byte(CMD_BREAK);
    end
    if (drop) begin
      repeat (6) @(negedge clk);
      send_byte(CMD_STEP);
    end
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if ((txlog.size() - tb0) >= exp_len && !tx_busy && !running) done = 1'b1;
    end
    repeat (6) @(negedge clk);
    halt_target = 0;

    n_vec++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d bytes, need %0d", name, txlog.size() - tb0, exp_len);
    end
    n_vec++;
    if (txlog.size() - tb0 != exp_len) begin
      n_bad++;
      $display("FAIL %s byte_count: got %0d, need %0d", name, txlog.size() - tb0, exp_len);
    end
    for (int i = 0; i < exp_len; i++) begin
      got = (tb0 + i < txlog.size()) ? txlog[tb0 + i] : 8'hxx;
      n_vec++;
      if (got !== exp_b[i]) begin
        n_bad++;
        $display("FAIL %s byte%0d: got %h, need %h", name, i, got, exp_b[i]);
      end
    end
    n_vec++;
    if (en_total - eb != exp_en) begin
      n_bad++;
      $display("FAIL %s pipe_en_cycles: got %0d, need %0d", name, en_total - eb, exp_en);
    end
    n_vec++;
    if (pre_total - pb != exp_pre) begin
      n_bad++;
      $display("FAIL %s pipe_reset_cycles: got %0d, need %0d", name, pre_total - pb, exp_pre);
    end
    n_vec++;
    if (run_total - rb != exp_run) begin
      n_bad++;
      $display("FAIL %s running_cycles: got %0d, need %0d", name, run_total - rb, exp_run);
    end
    n_vec++;
    if (viol_total != vb) begin
      n_bad++;
      $display("FAIL %s tx_start_while_busy: got %0d, need 0", name, viol_total - vb);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++; if (pipe_en !== 1'b0)    begin n_bad++; $display("FAIL reset pipe_en: got %b, need 0", pipe_en); end
    n_vec++; if (pipe_reset !== 1'b0) begin n_bad++; $display("FAIL reset pipe_reset: got %b, need 0", pipe_reset); end
    n_vec++; if (tx_start !== 1'b0)   begin n_bad++; $display("FAIL reset tx_start: got %b, need 0", tx_start); end
    n_vec++; if (running !== 1'b0)    begin n_bad++; $display("FAIL reset running: got %b, need 0", running); end
    n_vec++; if (tx_data !== 8'h00)   begin n_bad++; $display("FAIL reset tx_data: got %h, need 00", tx_data); end
    reset = 1'b0;
    m_pc = pc_value; m_cnt = 0; m_halt = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_step();
    test_cmd("preset", CMD_RESET, -1, 0, 1'b0);
    for (int i = 0; i < 3; i++) test_cmd("step", CMD_STEP, -1, 0, 1'b0);
  endtask

  task automatic test_run_halt();
    test_cmd("preset", CMD_RESET, -1, 0, 1'b0);
    test_cmd("run_halt", CMD_CONT, -1, int'($urandom_range(2, 15)), 1'b0);
    test_cmd("step_halted", CMD_STEP, -1, 0, 1'b0);
    test_cmd("cont_halted", CMD_CONT, 1, 3, 1'b0);
  endtask

  task automatic test_watchdog();
    test_cmd("preset", CMD_RESET, -1, 0, 1'b0);
    test_cmd("watchdog", CMD_CONT, -1, 0, 1'b0);
    n_vec++;
    if (running !== 1'b0) begin n_bad++; $display("FAIL watchdog running_after: got %b, need 0", running); end
    test_cmd("wd_and_halt", CMD_CONT, -1, 16, 1'b0);
  endtask

  task automatic test_nak_break();
    test_cmd("preset", CMD_RESET, -1, 0, 1'b0);
    test_cmd("nak_55", 8'h55, -1, 0, 1'b0);
    test_cmd("nak_break_idle", CMD_BREAK, -1, 0, 1'b0);
    test_cmd("break", CMD_CONT, 1, 0, 1'b0);
    test_cmd("break_and_halt", CMD_CONT, 3, 5, 1'b0);
  endtask

  task automatic test_drop();
    test_cmd("preset", CMD_RESET, -1, 0, 1'b0);
    test_cmd("drop_in_report", CMD_STEP, -1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_report();
    int tb0, sz;
    bit hit;
    test_cmd("preset", CMD_RESET, -1, 0, 1'b0);
    tb0 = txlog.size();
    send_byte(CMD_STEP);
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (txlog.size() - tb0 >= 4) hit = 1'b1;
    end
    n_vec++;
    if (!hit) begin n_bad++; $display("FAIL midreset timeout: got %0d bytes, need 4", txlog.size() - tb0); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++; if (pipe_en !== 1'b0)  begin n_bad++; $display("FAIL midreset pipe_en: got %b, need 0", pipe_en); end
    n_vec++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL midreset tx_start: got %b, need 0", tx_start); end
    n_vec++; if (running !== 1'b0)  begin n_bad++; $display("FAIL midreset running: got %b, need 0", running); end
    sz = txlog.size();
    repeat (40) @(negedge clk);
    n_vec++;
    if (txlog.size() != sz) begin n_bad++; $display("FAIL midreset extra_bytes: got %0d, need 0", txlog.size() - sz); end
    m_pc = m_pc + 32'd4; m_cnt = 0; m_halt = 1'b0;
    test_cmd("step_after_reset", CMD_STEP, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    int r, brk, h;
    logic [7:0] b;
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        test_cmd("rand_preset", CMD_RESET, -1, 0, 1'b0);
      end else if (r < 5) begin
        test_cmd("rand_step", CMD_STEP, -1, int'($urandom_range(0, 3)), 1'b0);
      end else if (r < 9) begin
        brk = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 18));
        h   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
        test_cmd("rand_cont", CMD_CONT, brk, h, 1'b0);
      end else begin
        do b = 8'($urandom); while (b == CMD_CONT || b == CMD_STEP || b == CMD_RESET);
        test_cmd("rand_nak", b, -1, 0, 1'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_halt();
    test_watchdog();
    test_nak_break();
    test_drop();
    test_reset_mid_report();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
